pattern_det: RTL and testbench

- Serial frame receiver/decoder for the single-bit pattern stream produced by the team's pattern generator.
- Samples `pattern` on every clock where `valid`=1 and checks for a fixed all-ones header. It then deserializes the DATA_W payload bits, MSB first, and presents them as a parallel word with a one-cycle strobe.
- Counts good frames and flags malformed or aborted frames; sits directly downstream of the generator in the lab datapath.

---
 rtl/pattern_det.sv | 130 +++++++++++++
 tb/tb_pattern_det.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pattern_det.sv
// rtl/pattern_det.sv - serial header/payload frame decoder with good-frame counter
// Optional PDET_ERR_CNT_EN adds err_cnt output and clr_cnt synchronous counter clear.
module pattern_det #(
    parameter int HDR_LEN = 3,
    parameter int DATA_W  = 2,
    parameter int CNT_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid,
    input  logic              pattern,
`ifdef PDET_ERR_CNT_EN
    input  logic              clr_cnt,
    output logic [CNT_W-1:0]  err_cnt,
`endif
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              frame_err,
    output logic              busy,
    output logic [CNT_W-1:0]  frame_cnt
);

    localparam int HW = $clog2(HDR_LEN + 1);
    localparam int DW = $clog2(DATA_W + 1);
    localparam logic [HW-1:0] HDR_LAST = HW'(HDR_LEN - 1);
    localparam logic [DW-1:0] DAT_LAST = DW'(DATA_W - 1);

    typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;

    state_t            state;
    logic [HW-1:0]     hdr_cnt;
    logic [DW-1:0]     dat_cnt;
    logic [DATA_W-1:0] shreg;
    logic [DATA_W-1:0] next_word;
    logic              err_event;
    logic              good_event;

    // A zero in the header or a dropped valid anywhere inside a frame is an error.
    assign err_event  = ((state == HDR) && (!valid || !pattern)) ||
                        ((state == DATA) && !valid);
    assign good_event = (state == DATA) && valid && (dat_cnt == DAT_LAST);
    assign next_word  = DATA_W'({shreg, pattern});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            hdr_cnt    <= '0;
            dat_cnt    <= '0;
            shreg      <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
            frame_cnt  <= '0;
`ifdef PDET_ERR_CNT_EN
            err_cnt    <= '0;
`endif
        end else begin
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (valid && pattern) begin
                        busy <= 1'b1;
                        if (HDR_LEN == 1) begin
                            state   <= DATA;
                            dat_cnt <= '0;
                        end else begin
                            state   <= HDR;
                            hdr_cnt <= HW'(1);
                        end
                    end
                end
                HDR: begin
                    if (err_event) begin
                        frame_err <= 1'b1;
                        state     <= IDLE;
                        busy      <= 1'b0;
                        hdr_cnt   <= '0;
                    end else if (hdr_cnt == HDR_LAST) begin
                        state   <= DATA;
                        hdr_cnt <= '0;
                        dat_cnt <= '0;
                    end else begin
                        hdr_cnt <= hdr_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (err_event) begin
                        frame_err <= 1'b1;
                        state     <= IDLE;
                        busy      <= 1'b0;
                        dat_cnt   <= '0;
                    end else begin
                        shreg <= next_word;
                        if (good_event) begin
                            data_out   <= next_word;
                            data_valid <= 1'b1;
                            state      <= IDLE;
                            busy       <= 1'b0;
                            dat_cnt    <= '0;
                        end else begin
                            dat_cnt <= dat_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase

`ifdef PDET_ERR_CNT_EN
            if (clr_cnt) begin
                frame_cnt <= '0;
                err_cnt   <= '0;
            end else begin
                if (good_event && (frame_cnt != '1))
                    frame_cnt <= frame_cnt + 1'b1;
                if (err_event && (err_cnt != '1))
                    err_cnt <= err_cnt + 1'b1;
            end
`else
            if (good_event && (frame_cnt != '1))
                frame_cnt <= frame_cnt + 1'b1;
`endif
        end
    end

endmodule

// File: tb/tb_pattern_det.sv
// tb/tb_pattern_det.sv - directed self-checking bench for pattern_det
// Exercises PDET_ERR_CNT_EN ports and checks when that macro is defined.
module tb_pattern_det;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       valid = 1'b0;
    logic       pattern = 1'b0;
    logic [1:0] data_out;
    logic       data_valid;
    logic       frame_err;
    logic       busy;
    logic [7:0] frame_cnt;
    logic [1:0] s_data_out;
    logic       s_data_valid;
    logic       s_frame_err;
    logic       s_busy;
    logic [1:0] s_frame_cnt;
`ifdef PDET_ERR_CNT_EN
    logic       clr_cnt = 1'b0;
    logic [7:0] err_cnt;
    logic [1:0] s_err_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pattern_det #(.HDR_LEN(3), .DATA_W(2), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .valid(valid), .pattern(pattern),
`ifdef PDET_ERR_CNT_EN
        .clr_cnt(clr_cnt), .err_cnt(err_cnt),
`endif
        .data_out(data_out), .data_valid(data_valid), .frame_err(frame_err),
        .busy(busy), .frame_cnt(frame_cnt)
    );

    pattern_det #(.HDR_LEN(3), .DATA_W(2), .CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .valid(valid), .pattern(pattern),
`ifdef PDET_ERR_CNT_EN
        .clr_cnt(clr_cnt), .err_cnt(s_err_cnt),
`endif
        .data_out(s_data_out), .data_valid(s_data_valid), .frame_err(s_frame_err),
        .busy(s_busy), .frame_cnt(s_frame_cnt)
    );

    task automatic send_bit(input logic v, input logic p);
        valid   = v;
        pattern = p;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (data_out !== 2'b00) begin n_fail++; $display("FAIL reset_data_out got %b exp 00", data_out); end
        n_checks++;
        if (data_valid !== 1'b0 || frame_err !== 1'b0) begin
            n_fail++; $display("FAIL reset_strobes got dv=%b fe=%b exp 0 0", data_valid, frame_err);
        end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
        n_checks++;
        if (frame_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_frame_cnt got %0d exp 0", frame_cnt); end
    endtask

    task automatic test_frame();
        logic [4:0] bits = 5'b11110;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            send_bit(1'b1, bits[4-i]);
            n_checks++;
            if (data_valid !== (i == 4)) begin
                n_fail++; $display("FAIL frame_dv bit%0d got %b exp %b", i, data_valid, (i == 4));
            end
            n_checks++;
            if (frame_err !== 1'b0) begin n_fail++; $display("FAIL frame_err bit%0d got %b exp 0", i, frame_err); end
            n_checks++;
            if (busy !== (i != 4)) begin n_fail++; $display("FAIL frame_busy bit%0d got %b exp %b", i, busy, (i != 4)); end
        end
        n_checks++;
        if (data_out !== 2'b10) begin n_fail++; $display("FAIL frame_data got %b exp 10", data_out); end
        n_checks++;
        if (frame_cnt !== 8'd1) begin n_fail++; $display("FAIL frame_cnt got %0d exp 1", frame_cnt); end
        send_bit(1'b0, 1'b0);
        n_checks++;
        if (data_valid !== 1'b0) begin n_fail++; $display("FAIL frame_dv_width got %b exp 0", data_valid); end
    endtask

    task automatic test_back_to_back();
        logic [9:0] bits = 10'b11101_11111;
        int dv_seen = 0;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            send_bit(1'b1, bits[9-i]);
            if (data_valid === 1'b1) dv_seen++;
            n_checks++;
            if (data_valid !== (i == 4 || i == 9)) begin
                n_fail++; $display("FAIL b2b_dv bit%0d got %b exp %b", i, data_valid, (i == 4 || i == 9));
            end
            if (i == 4) begin
                n_checks++;
                if (data_out !== 2'b01) begin n_fail++; $display("FAIL b2b_data1 got %b exp 01", data_out); end
            end
            if (i == 5) begin
                n_checks++;
                if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_busy_reentry got %b exp 1", busy); end
            end
        end
        n_checks++;
        if (data_out !== 2'b11 || dv_seen != 2) begin
            n_fail++; $display("FAIL b2b_data2 got %b pulses %0d exp 11 pulses 2", data_out, dv_seen);
        end
        n_checks++;
        if (frame_cnt !== 8'd2) begin n_fail++; $display("FAIL b2b_cnt got %0d exp 2", frame_cnt); end
    endtask

    task automatic test_hdr_mismatch();
        logic [4:0] good = 5'b11100;
        send_bit(1'b1, 1'b1);
        send_bit(1'b1, 1'b1);
        send_bit(1'b1, 1'b0);
        n_checks++;
        if (frame_err !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL hdr_err got fe=%b busy=%b exp 1 0", frame_err, busy);
        end
        send_bit(1'b0, 1'b0);
        n_checks++;
        if (frame_err !== 1'b0 || frame_cnt !== 8'd2 || data_out !== 2'b11) begin
            n_fail++; $display("FAIL hdr_after got fe=%b cnt=%0d data=%b exp 0 2 11", frame_err, frame_cnt, data_out);
        end
        for (int i = 0; i < 5; i++) send_bit(1'b1, good[4-i]);
        n_checks++;
        if (data_valid !== 1'b1 || data_out !== 2'b00 || frame_cnt !== 8'd3) begin
            n_fail++; $display("FAIL hdr_recover got dv=%b data=%b cnt=%0d exp 1 00 3", data_valid, data_out, frame_cnt);
        end
    endtask

    task automatic test_abort();
        logic [4:0] good = 5'b11110;
        do_reset();
        for (int i = 0; i < 5; i++) send_bit(1'b1, good[4-i]);
        for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b1);
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL abort_busy_pre got %b exp 1", busy); end
        send_bit(1'b0, 1'b1);
        n_checks++;
        if (frame_err !== 1'b1 || data_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL abort_err got fe=%b dv=%b busy=%b exp 1 0 0", frame_err, data_valid, busy);
        end
        n_checks++;
        if (data_out !== 2'b10 || frame_cnt !== 8'd1) begin
            n_fail++; $display("FAIL abort_hold got data=%b cnt=%0d exp 10 1", data_out, frame_cnt);
        end
        for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b1);
        rst = 1'b1;
        #1;
        n_checks++;
        if (data_out !== 2'b00 || busy !== 1'b0 || frame_cnt !== 8'd0 || data_valid !== 1'b0 || frame_err !== 1'b0) begin
            n_fail++; $display("FAIL async_rst got data=%b busy=%b cnt=%0d dv=%b fe=%b exp all 0",
                               data_out, busy, frame_cnt, data_valid, frame_err);
        end
        valid = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (data_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL rst_hold got dv=%b busy=%b exp 0 0", data_valid, busy);
        end
        rst   = 1'b0;
        valid = 1'b0;
        send_bit(1'b0, 1'b0);
    endtask

    task automatic test_saturation();
        logic [4:0] good = 5'b11101;
        logic [1:0] exp_cnt;
        do_reset();
        n_checks++;
        if (s_frame_cnt !== 2'd0) begin n_fail++; $display("FAIL sat_cnt0 got %0d exp 0", s_frame_cnt); end
        for (int f = 1; f <= 5; f++) begin
            for (int i = 0; i < 5; i++) send_bit(1'b1, good[4-i]);
            exp_cnt = (f > 3) ? 2'd3 : 2'(f);
            n_checks++;
            if (s_frame_cnt !== exp_cnt) begin
                n_fail++; $display("FAIL sat_cnt frame%0d got %0d exp %0d", f, s_frame_cnt, exp_cnt);
            end
        end
    endtask

`ifdef PDET_ERR_CNT_EN
    task automatic test_err_cnt();
        do_reset();
        for (int k = 0; k < 3; k++) begin
            send_bit(1'b1, 1'b1);
            send_bit(1'b1, 1'b0);
        end
        n_checks++;
        if (err_cnt !== 8'd3) begin n_fail++; $display("FAIL err_cnt got %0d exp 3", err_cnt); end
        send_bit(1'b1, 1'b1);
        clr_cnt = 1'b1;
        send_bit(1'b1, 1'b0);
        clr_cnt = 1'b0;
        n_checks++;
        if (err_cnt !== 8'd0 || frame_err !== 1'b1) begin
            n_fail++; $display("FAIL err_clr got cnt=%0d fe=%b exp 0 1", err_cnt, frame_err);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_frame();
        test_back_to_back();
        test_hdr_mismatch();
        test_abort();
        test_saturation();
`ifdef PDET_ERR_CNT_EN
        test_err_cnt();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Strobes must never coincide; checked on every falling edge.
    always @(negedge clk) begin
        if (!rst) begin
            n_checks++;
            if (data_valid === 1'b1 && frame_err === 1'b1) begin
                n_fail++; $display("FAIL strobe_overlap got dv=1 fe=1 exp not both");
            end
        end
    end

endmodule
